// File: rtl/ped_walk_controller.sv
// Pedestrian WALK/DONT_WALK head slaved to the NS green phase, with flash countdown and a sticky lamp-conflict fault.
// Registered outputs; a request latched in any state is served at the next NS green rising edge.
module ped_walk_controller #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int WALK_SEC  = 7,
    parameter int FLASH_SEC = 9,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       ns_red,
    input  logic       ns_yellow,
    input  logic       ns_green,
    input  logic       ew_red,
    input  logic       ew_yellow,
    input  logic       ew_green,
    output logic       walk,
    output logic       dont_walk,
    output logic [3:0] countdown,
    output logic       req_pending,
    output logic       fault
);

    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int SEC_W   = $clog2(WALK_SEC + 1);
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WALK  = 2'd1;
    localparam logic [1:0] S_FLASH = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               ns_green_q;
    logic [TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               walk_q, walk_d;
    logic               dont_walk_q, dont_walk_d;
    logic [3:0]         countdown_q, countdown_d;
    logic               req_q, req_d;
    logic               fault_q, fault_d;

    logic fault_cond, rise, tick, blink_end, grant, entering;

    always_comb begin
        fault_cond = (ns_green & ew_green)
                   | (ns_red & ns_yellow) | (ns_red & ns_green) | (ns_yellow & ns_green)
                   | (ew_red & ew_yellow) | (ew_red & ew_green) | (ew_yellow & ew_green);
        fault_d    = fault_q | fault_cond;
        rise       = ns_green & ~ns_green_q;
        tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
        blink_end  = (blink_q == BLINK_W'(BLINK_DIV - 1));
        // A conflict seen on the very edge of the rise already blocks the grant.
        grant      = (state_q == S_IDLE) & rise & (req_q | ped_req) & ~fault_d;
        req_d      = grant ? 1'b0 : (req_q | ped_req);

        state_d     = state_q;
        sec_d       = sec_q;
        countdown_d = countdown_q;

        case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_WALK;
            end
            S_WALK: begin
                if (!ns_green || (tick && sec_q == SEC_W'(1))) state_d = S_FLASH;
                else if (tick)                                 sec_d   = sec_q - SEC_W'(1);
            end
            S_FLASH: begin
                if (ns_red || (tick && countdown_q == 4'd1)) state_d     = S_IDLE;
                else if (tick)                               countdown_d = countdown_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (fault_d) state_d = S_IDLE;

        entering = (state_d != state_q);
        if (entering) begin
            tick_cnt_d  = '0;
            blink_d     = '0;
            sec_d       = SEC_W'(WALK_SEC);
            countdown_d = 4'(FLASH_SEC);
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
            blink_d    = blink_end ? '0 : blink_q + BLINK_W'(1);
        end

        walk_d = (state_d == S_WALK);
        if (state_d == S_FLASH) begin
            dont_walk_d = entering ? 1'b1 : (dont_walk_q ^ blink_end);
        end else begin
            dont_walk_d = (state_d != S_WALK);
            countdown_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ns_green_q  <= 1'b0;
            tick_cnt_q  <= '0;
            sec_q       <= '0;
            blink_q     <= '0;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            countdown_q <= 4'd0;
            req_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ns_green_q  <= ns_green;
            tick_cnt_q  <= tick_cnt_d;
            sec_q       <= sec_d;
            blink_q     <= blink_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            countdown_q <= countdown_d;
            req_q       <= req_d;
            fault_q     <= fault_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign countdown   = countdown_q;
    assign req_pending = req_q;
    assign fault       = fault_q;

endmodule
